serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 11 +
 rtl/serial_subtractor_fs.sv | 33 +++
 rtl/serial_subtractor.sv | 94 +++++++++
 tb/tb_serial_subtractor.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
// Holds the FSM state encoding used by the top level.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_fs.sv
// Combinational full-subtractor cell.
// Two-input NAND network, same shape as the adder carry cell.
module fs_cell (
    output logic diff,
    output logic bout,
    input  logic a,
    input  logic b,
    input  logic bin
);

    logic n1, n2, n3, x;
    logic m1, m2, m3;
    logic na, nx, p, q;

    // x = a ^ b from four NANDs
    assign n1 = ~(a & b);
    assign n2 = ~(a & n1);
    assign n3 = ~(b & n1);
    assign x  = ~(n2 & n3);

    assign m1   = ~(x & bin);
    assign m2   = ~(x & m1);
    assign m3   = ~(bin & m1);
    assign diff = ~(m2 & m3);

    // bout = (~a & b) | (~x & bin)
    assign na   = ~(a & a);
    assign nx   = ~(x & x);
    assign p    = ~(na & b);
    assign q    = ~(nx & bin);
    assign bout = ~(p & q);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin, LSB first.
// One fs_cell is reused every RUN cycle.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d_bit;
    logic             b_bit;
    logic             last;

    fs_cell u_cell (
        .diff (d_bit),
        .bout (b_bit),
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (br)
    );

    assign last = (cnt == CW'(WIDTH - 1));
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        br  <= bin;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= b_bit;
                    res <= {d_bit, res[WIDTH-1:1]};
                    // Outputs move only on the final bit
                    if (last) begin
                        diff <= {d_bit, res[WIDTH-1:1]};
                        bout <= b_bit;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor.
// Driver pushes a-b-bin expectations; monitor pops on done.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   run = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(string name, longint act, longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y,
                                   logic c, int k);
        exp_t e;
        int   r;
        r     = int'(x) - int'(y) - int'(c);
        e.d   = W'(r + (1 << W));
        e.bo  = (int'(x) < int'(y) + int'(c));
        e.cyc = k + W;
        return e;
    endfunction

    // Sets operands, gets them accepted, leaves start low in RUN cycle 1.
    task automatic start_op(logic [W-1:0] x, logic [W-1:0] y,
                            logic c, bit expect_done);
        @(negedge clk);
        a = x; b = y; bin = c; start = 1'b1;
        @(posedge clk);
        #1;
        if (expect_done) q.push_back(model(x, y, c, cyc));
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    endtask

    task automatic op(logic [W-1:0] x, logic [W-1:0] y, logic c);
        start_op(x, y, c, 1'b1);
        repeat (W + 1) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (busy && done) chk("busy_done_overlap", 1, 0);
        if (busy) run++;
        if (done) begin
            chk("busy_len", run, W);
            run = 0;
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("diff", diff, e.d);
                chk("bout", bout, e.bo);
                chk("done_cycle", cyc, e.cyc);
            end
        end else if (!busy) begin
            run = 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        a = 8'h12; b = 8'h34; bin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk);

        op(8'h05, 8'h03, 1'b0);
        op(8'h00, 8'h01, 1'b0);
        op(8'h10, 8'h0F, 1'b1);
        op(8'hFF, 8'hFF, 1'b1);

        // Start ignored mid-run
        start_op(8'h09, 8'h04, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (W - 2) @(posedge clk);

        // Reset in RUN cycle 4 aborts the operation
        start_op(8'h80, 8'h01, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 0);
        chk("abort_bout", bout, 0);
        repeat (W + 3) @(posedge clk);
        op(8'h80, 8'h01, 1'b0);

        // Start held high: one accept every W+2 edges
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] x, y;
            logic         c;
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            if (i == 0) begin x = '0; y = '1; c = 1'b1; end
            if (i == 1) begin x = '1; y = '0; c = 1'b0; end
            @(negedge clk);
            a = x; b = y; bin = c; start = 1'b1;
            @(posedge clk);
            #1;
            q.push_back(model(x, y, c, cyc));
            for (int j = 0; j <= W; j++) begin
                @(negedge clk);
                a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
                @(posedge clk);
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (W + 4) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
